// File: rtl/alu_operand_seq_if.sv
// Bus bundle between the ALU operand sequencer (slave) and its surroundings (master):
// the shared input bus and strobes, the ALU operand/result loop, and the captured outputs.
interface alu_operand_seq_if #(
    parameter int W = 4
);
    logic [W-1:0] din;
    logic         load;
    logic         clear;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [3:0]   alu_op;
    logic [W-1:0] alu_result;
    logic         alu_n;
    logic         alu_z;
    logic         alu_c;
    logic         alu_v;
    logic [W-1:0] result;
    logic [3:0]   flags;
    logic         done;
    logic [2:0]   state;
    logic         err;

    modport slave (
        input  din, load, clear, alu_result, alu_n, alu_z, alu_c, alu_v,
        output alu_a, alu_b, alu_op, result, flags, done, state, err
    );

    modport master (
        output din, load, clear, alu_result, alu_n, alu_z, alu_c, alu_v,
        input  alu_a, alu_b, alu_op, result, flags, done, state, err
    );
endinterface

// File: rtl/alu_operand_seq.sv
// Sequential front end for the combinational ALU: collects A, B and opcode from one bus,
// executes for one cycle, captures result/flags. Optional macro: ALU_DIV0_GUARD_EN.
module alu_operand_seq #(
    parameter int W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_operand_seq_if.slave bus
);
    typedef enum logic [2:0] {
        S_A    = 3'd0,
        S_B    = 3'd1,
        S_OP   = 3'd2,
        S_EXEC = 3'd3,
        S_SHOW = 3'd4
    } state_t;

    state_t       r_state;
    logic [W-1:0] r_a;
    logic [W-1:0] r_b;
    logic [3:0]   r_op;
    logic [W-1:0] r_result;
    logic [3:0]   r_flags;
    logic         r_done;

`ifdef ALU_DIV0_GUARD_EN
    logic r_err;
    logic w_div0;

    // Divide and modulo by zero are intercepted before the ALU's output is trusted.
    assign w_div0 = ((r_op == 4'b0011) || (r_op == 4'b0100)) && (r_b == '0);
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values; blocking here would make ordering inside the block matter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_A;
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= '0;
            r_result <= '0;
            r_flags  <= '0;
            r_done   <= 1'b0;
`ifdef ALU_DIV0_GUARD_EN
            r_err    <= 1'b0;
`endif
        end else if (bus.clear) begin
            r_state  <= S_A;
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= '0;
            r_result <= '0;
            r_flags  <= '0;
            r_done   <= 1'b0;
`ifdef ALU_DIV0_GUARD_EN
            r_err    <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_A: begin
                    if (bus.load) begin
                        r_a     <= bus.din;
                        r_state <= S_B;
                    end
                end
                S_B: begin
                    if (bus.load) begin
                        r_b     <= bus.din;
                        r_state <= S_OP;
                    end
                end
                S_OP: begin
                    if (bus.load) begin
                        r_op    <= bus.din[3:0];
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    // Operands have been stable all cycle; a load strobe here is dropped.
`ifdef ALU_DIV0_GUARD_EN
                    if (w_div0) begin
                        r_result <= '0;
                        r_flags  <= 4'b0100;
                        r_err    <= 1'b1;
                    end else begin
                        r_result <= bus.alu_result;
                        r_flags  <= {bus.alu_n, bus.alu_z, bus.alu_c, bus.alu_v};
                    end
`else
                    r_result <= bus.alu_result;
                    r_flags  <= {bus.alu_n, bus.alu_z, bus.alu_c, bus.alu_v};
`endif
                    r_done  <= 1'b1;
                    r_state <= S_SHOW;
                end
                S_SHOW: begin
                    // A new operation starts with operand A; the old result stays visible.
                    if (bus.load) begin
                        r_a     <= bus.din;
                        r_done  <= 1'b0;
`ifdef ALU_DIV0_GUARD_EN
                        r_err   <= 1'b0;
`endif
                        r_state <= S_B;
                    end
                end
                default: r_state <= S_A;
            endcase
        end
    end

    assign bus.alu_a  = r_a;
    assign bus.alu_b  = r_b;
    assign bus.alu_op = r_op;
    assign bus.result = r_result;
    assign bus.flags  = r_flags;
    assign bus.done   = r_done;
    assign bus.state  = r_state;
`ifdef ALU_DIV0_GUARD_EN
    assign bus.err    = r_err;
`else
    assign bus.err    = 1'b0;
`endif
endmodule
